regfile_2r1w_clr: RTL and testbench
===================================

// Module: regfile_2r1w_clr
// PURPOSE
//  Parametrised register file: 2 read ports, 1 write port, single clock.
//  Generalised successor of the team's 32x32 dual-port register block.
//  Adds registered read ports, write-to-read forwarding and an optional hardwired zero entry.
//  Adds a sequenced soft-clear engine that sweeps all entries to zero without a reset.
//  Sits in the CPU datapath between decode (read addrs) and writeback (write port).
// PARAMETERS
//  DATA_W    32                 data width in bits
//  DEPTH     32                 number of entries (>=2; need not be a power of 2)
//  ADDR_W    $clog2(DEPTH)      address width (derived; do not override)
//  ZERO_REG  1                  1: entry 0 reads as zero and ignores writes; 0: entry 0 is normal
//  BYPASS    1                  1: same-edge write data is forwarded to a matching read; 0: no forwarding
// PORTS
//  clk       in   1       clock; all state updates on posedge
//  rst_n     in   1       asynchronous reset, active low
//  we        in   1       write enable
//  waddr     in   ADDR_W  write address
//  wdata     in   DATA_W  write data
//  re0       in   1       read enable, port 0
//  raddr0    in   ADDR_W  read address, port 0
//  rdata0    out  DATA_W  registered read data, port 0
//  re1       in   1       read enable, port 1
//  raddr1    in   ADDR_W  read address, port 1
//  rdata1    out  DATA_W  registered read data, port 1
//  clr_req   in   1       soft-clear request (single-cycle pulse or level; sampled in IDLE only)
//  clr_busy  out  1       high while the clear sweep is in progress
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - All entries are set to 0.
//   - rdata0, rdata1 and clr_busy are set to 0.
//   - FSM goes to IDLE and the sweep index is set to 0.
//   - This applies mid-sweep as well: the sweep aborts and all entries read 0.
//  Write: at posedge, mem[waddr]<=wdata when we=1, the FSM is in IDLE, waddr<DEPTH, and not (ZERO_REG && waddr==0).
//  Read: 1-cycle latency. At posedge with reN=1, rdataN<=value(raddrN). With reN=0, rdataN holds.
//  value(a) is resolved in this priority order:
//   - a>=DEPTH -> 0.
//   - ZERO_REG && a==0 -> 0.
//   - A clear-sweep write to a this edge -> 0.
//   - BYPASS && an accepted write to a this edge -> wdata.
//   - Otherwise mem[a] before the edge.
//  With BYPASS=0, a read of the address being written returns the old contents.
//  Both ports may read the same address in the same cycle; both return the same value.
//  FSM:
//   - IDLE: clr_busy=0. clr_req=1 at posedge -> CLEAR, index<=0.
//   - CLEAR: clr_busy=1. Each posedge sets mem[index]<=0 and index<=index+1.
//   - CLEAR -> IDLE at the posedge that clears index DEPTH-1; index<=0.
//  Sweep timing:
//   - clr_busy is high for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
//   - A write presented in the same cycle clr_req is sampled is performed; the sweep then overwrites it.
//  During CLEAR:
//   - we is ignored: no write, no forwarding.
//   - clr_req is ignored: no restart, no queueing.
//   - Reads remain legal and return the current contents; entries not yet swept keep their old data.
//  clr_req held high continuously starts a new sweep on the posedge after each return to IDLE (one IDLE cycle between sweeps).
//  Index counter width is ADDR_W; it never exceeds DEPTH-1.
// TESTING
//  1. Reset state:
//     - Stimulus: DATA_W=32, DEPTH=32; assert rst_n=0 mid-cycle.
//     - Required: rdata0, rdata1 and clr_busy go to 0 immediately.
//     - Required: after release, reads of addrs 0..31 all return 0 one cycle after re.
//  2. Write/read and latency:
//     - Stimulus: write 0xDEADBEEF to addr 5; next cycle re0=1, raddr0=5.
//     - Required: rdata0=0xDEADBEEF after that edge; rdata0 holds while re0=0.
//  3. Forwarding:
//     - Stimulus: same cycle we=1, waddr=7, wdata=0x1234, re0=re1=1, raddr0=raddr1=7.
//     - Required: BYPASS=1 -> both ports return 0x1234; BYPASS=0 -> both return the prior value.
//  4. Zero entry:
//     - Stimulus: ZERO_REG=1; write 0xFFFFFFFF to addr 0, then read addr 0.
//     - Required: returns 0.
//     - Stimulus: ZERO_REG=0, same sequence.
//     - Required: returns 0xFFFFFFFF.
//  5. Clear sweep:
//     - Stimulus: fill all 32 entries with nonzero data; pulse clr_req.
//     - Required: clr_busy high for exactly 32 cycles.
//     - Required: a read of addr 20 during busy cycle 10 returns old data.
//     - Required: we ignored during busy; after the sweep all entries read 0.
//  6. Reset mid-sweep and odd depth:
//     - Stimulus: DEPTH=24; assert rst_n at busy cycle 5.
//     - Required: clr_busy drops at once and all entries read 0.
//     - Required: accesses to addrs 24..31 write nothing and read 0.

Source files
------------

// File: rtl/regfile_2r1w_clr.sv
// Parametrised 2-read/1-write register file with registered read ports,
// same-edge write forwarding, optional hardwired zero entry and a soft-clear sweep.
module regfile_2r1w_clr #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clr_req,
    output logic              clr_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_acc;
    logic              clr_wr;
    logic [DATA_W-1:0] rd_val0;
    logic [DATA_W-1:0] rd_val1;

    // Widened compare so non-power-of-two depths reject the unused top addresses.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign clr_wr   = (state == ST_CLEAR);
    assign wr_acc   = we && (state == ST_IDLE) && in_range(waddr) && !is_zero_entry(waddr);
    assign clr_busy = (state == ST_CLEAR);

    // Read value resolution: range, zero entry, sweep write, forwarded write, stored data.
    always_comb begin
        rd_val0 = '0;
        if (in_range(raddr0) && !is_zero_entry(raddr0) && !(clr_wr && (raddr0 == clr_idx))) begin
            if (BYPASS && wr_acc && (waddr == raddr0)) begin
                rd_val0 = wdata;
            end else begin
                rd_val0 = mem[raddr0];
            end
        end
    end

    always_comb begin
        rd_val1 = '0;
        if (in_range(raddr1) && !is_zero_entry(raddr1) && !(clr_wr && (raddr1 == clr_idx))) begin
            if (BYPASS && wr_acc && (waddr == raddr1)) begin
                rd_val1 = wdata;
            end else begin
                rd_val1 = mem[raddr1];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_nxt   = ST_IDLE;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clr_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Host writes and sweep writes never coincide: host writes are accepted only in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_acc) begin
                mem[waddr] <= wdata;
            end
            if (clr_wr) begin
                mem[clr_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (re0) begin
                rdata0 <= rd_val0;
            end
            if (re1) begin
                rdata1 <= rd_val1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Bench for regfile_2r1w_clr: three configurations share one stimulus stream,
// each checked against an array-based reference model through an expected queue.
module tb_regfile_2r1w_clr;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re0 = 1'b0;
    logic [4:0]  raddr0 = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic        clr_req = 1'b0;

    logic [31:0] rd0  [NI];
    logic [31:0] rd1  [NI];
    logic        busy [NI];

    int cfg_depth [NI] = '{32, 32, 24};
    bit cfg_zr    [NI] = '{1'b1, 1'b0, 1'b1};
    bit cfg_bp    [NI] = '{1'b1, 1'b0, 1'b1};

    logic [31:0] ref_mem  [NI][32];
    int          sweep_at [NI];
    logic [31:0] hold0    [NI];
    logic [31:0] hold1    [NI];

    logic [64:0] exp_q0[$];
    logic [64:0] exp_q1[$];
    logic [64:0] exp_q2[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_2r1w_clr #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_std (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .raddr0(raddr0), .rdata0(rd0[0]),
        .re1(re1), .raddr1(raddr1), .rdata1(rd1[0]),
        .clr_req(clr_req), .clr_busy(busy[0])
    );

    regfile_2r1w_clr #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_plain (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .raddr0(raddr0), .rdata0(rd0[1]),
        .re1(re1), .raddr1(raddr1), .rdata1(rd1[1]),
        .clr_req(clr_req), .clr_busy(busy[1])
    );

    regfile_2r1w_clr #(.DATA_W(32), .DEPTH(24), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .raddr0(raddr0), .rdata0(rd0[2]),
        .re1(re1), .raddr1(raddr1), .rdata1(rd1[2]),
        .clr_req(clr_req), .clr_busy(busy[2])
    );

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d got %h exp %h", name, k, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 32; a++) ref_mem[k][a] = '0;
            sweep_at[k] = -1;
            hold0[k] = '0;
            hold1[k] = '0;
        end
    endtask

    function automatic logic [31:0] ref_read(input int k, input int a, input bit wr_ok);
        if (a >= cfg_depth[k]) return '0;
        if (cfg_zr[k] && a == 0) return '0;
        if (sweep_at[k] == a) return '0;
        if (cfg_bp[k] && wr_ok && int'(waddr) == a) return wdata;
        return ref_mem[k][a];
    endfunction

    // Predict the outputs after the coming edge from the inputs now on the bus.
    task automatic model_step(input int k);
        bit          wr_ok;
        logic        bnext;
        logic [64:0] e;
        wr_ok = we && (sweep_at[k] < 0) && (int'(waddr) < cfg_depth[k]) && !(cfg_zr[k] && waddr == 0);
        if (re0) hold0[k] = ref_read(k, int'(raddr0), wr_ok);
        if (re1) hold1[k] = ref_read(k, int'(raddr1), wr_ok);
        if (sweep_at[k] < 0) bnext = clr_req;
        else bnext = (sweep_at[k] != cfg_depth[k] - 1);
        e = {bnext, hold1[k], hold0[k]};
        case (k)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
        if (wr_ok) ref_mem[k][waddr] = wdata;
        if (sweep_at[k] >= 0) begin
            ref_mem[k][sweep_at[k]] = '0;
            sweep_at[k] = (sweep_at[k] == cfg_depth[k] - 1) ? -1 : sweep_at[k] + 1;
        end else if (clr_req) begin
            sweep_at[k] = 0;
        end
    endtask

    task automatic compare_entry(input int k, input logic [64:0] e);
        check("rdata0", k, rd0[k], e[31:0]);
        check("rdata1", k, rd1[k], e[63:32]);
        check("clr_busy", k, {31'd0, busy[k]}, {31'd0, e[64]});
    endtask

    // Monitor: one expected entry per driven edge, sampled 1 time unit after it.
    initial begin
        logic [64:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); compare_entry(0, e); end
                if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); compare_entry(1, e); end
                if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); compare_entry(2, e); end
            end
        end
    end

    task automatic drive(input bit w, input int wa, input logic [31:0] wd,
                         input bit r0, input int a0, input bit r1, input int a1, input bit c);
        we      = w;
        waddr   = 5'(wa);
        wdata   = wd;
        re0     = r0;
        raddr0  = 5'(a0);
        re1     = r1;
        raddr1  = 5'(a1);
        clr_req = c;
        for (int k = 0; k < NI; k++) model_step(k);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        we = 1'b0; re0 = 1'b0; re1 = 1'b0; clr_req = 1'b0;
    endtask

    // Assert reset mid-cycle and check outputs clear without waiting for a clock edge.
    task automatic do_reset();
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_rdata0", k, rd0[k], 32'd0);
            check("rst_rdata1", k, rd1[k], 32'd0);
            check("rst_busy", k, {31'd0, busy[k]}, 32'd0);
        end
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, i, 1, i + 16, 0);
    endtask

    task automatic fill_all();
        for (int i = 0; i < 32; i++)
            drive(1, i, $urandom | 32'd1, 1, $urandom_range(0, 31), 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Put nonzero data on the outputs, then reset mid-cycle.
        drive(1, 3, 32'hA5A5_0003, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 1, 3, 0);
        do_reset();
        read_all();

        // Write then read with one-cycle latency; outputs hold while re is low.
        drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 5, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 9, 0, 9, 0);

        // Same-edge forwarding on both ports.
        drive(1, 7, 32'hAAAA_5555, 0, 0, 0, 0, 0);
        drive(1, 7, 32'h0000_1234, 1, 7, 1, 7, 0);
        drive(0, 0, 0, 1, 7, 1, 7, 0);

        // Zero entry.
        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 0, 0);

        // Clear sweep with a write in the request cycle and writes ignored while busy.
        fill_all();
        drive(1, 9, 32'hCAFE_F00D, 1, 9, 0, 0, 1);
        for (int j = 0; j < 40; j++)
            drive(1, $urandom_range(0, 31), $urandom | 32'd1,
                  1, (j == 10) ? 20 : $urandom_range(0, 31), 1, $urandom_range(0, 31), 0);
        read_all();

        // clr_req held high: back-to-back sweeps with one IDLE cycle between.
        fill_all();
        for (int j = 0; j < 80; j++)
            drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom,
                  1, $urandom_range(0, 31), 1, $urandom_range(0, 31), 1);
        for (int j = 0; j < 34; j++) drive(0, 0, 0, 1, $urandom_range(0, 31), 0, 0, 0);
        read_all();

        // Reset in the middle of a sweep.
        fill_all();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) drive(0, 0, 0, 1, 30, 1, 2, 0);
        do_reset();
        read_all();

        // Top addresses on the 24-entry instance.
        for (int i = 24; i < 32; i++) drive(1, i, $urandom | 32'd1, 0, 0, 0, 0, 0);
        for (int i = 24; i < 32; i++) drive(0, 0, 0, 1, i, 1, i, 0);

        // Random mix.
        for (int j = 0; j < 300; j++)
            drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, 31),
                  ($urandom_range(0, 19) == 0));

        idle_inputs();
        @(posedge clk);
        #2;
        n_checks++;
        if ((exp_q0.size() + exp_q1.size() + exp_q2.size()) == 0) n_pass++;
        else $display("FAIL drain left %0d expected %0d", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
